// File: rtl/dp_ram_pkg.sv
// Shared sizing constants for the single-clock, port-selected dual-port RAM.
package dp_ram_pkg;
   localparam int unsigned DATA_W_DEF = 3;
   localparam int unsigned ADDR_W_DEF = 3;
   localparam int unsigned DEPTH      = 2 ** ADDR_W_DEF;
endpackage : dp_ram_pkg

// File: rtl/dp_ram_if.sv
// Bus bundle for dp_ram: port select, operation, both ports' address/data and read-back.
interface dp_ram_if
   import dp_ram_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
);
   logic              cs;
   logic              we;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] data_a;
   logic [DATA_W-1:0] data_b;
   logic [DATA_W-1:0] data_aout;
   logic [DATA_W-1:0] data_bout;

   modport master (
      output cs, we, addr_a, addr_b, data_a, data_b,
      input  data_aout, data_bout
   );

   modport slave (
      input  cs, we, addr_a, addr_b, data_a, data_b,
      output data_aout, data_bout
   );
endinterface : dp_ram_if

// File: rtl/dp_ram.sv
// Shared word array with one active port per cycle (chosen by cs); registered read data per port.
module dp_ram
   import dp_ram_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic     clk,
   input  logic     rst_n,
   dp_ram_if.slave  bus
);
   localparam int unsigned DEPTH_L = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH_L];
   logic [ADDR_W-1:0] sel_addr_c;
   logic [DATA_W-1:0] sel_data_c;
   logic [DATA_W-1:0] aout_q;
   logic [DATA_W-1:0] bout_q;

   // The inactive port's address and data never reach the array
   always_comb begin
      sel_addr_c = bus.addr_b;
      sel_data_c = bus.data_b;
      if (bus.cs) begin
         sel_addr_c = bus.addr_a;
         sel_data_c = bus.data_a;
      end
   end

   // Storage is resettable so an asserted reset discards all stored words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH_L); i++) begin
            mem[i] <= '0;
         end
      end else if (bus.we) begin
         mem[sel_addr_c] <= sel_data_c;
      end
   end

   // Only the selected port's read register loads; the other one holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aout_q <= '0;
         bout_q <= '0;
      end else if (!bus.we) begin
         if (bus.cs) begin
            aout_q <= mem[sel_addr_c];
         end else begin
            bout_q <= mem[sel_addr_c];
         end
      end
   end

   assign bus.data_aout = aout_q;
   assign bus.data_bout = bout_q;
endmodule : dp_ram

// File: tb/tb_dp_ram.sv
// Directed self-checking bench for dp_ram: reset, fill, cross-port overwrite, inactive-port isolation.
module tb_dp_ram;
   localparam int unsigned DW = 3;
   localparam int unsigned AW = 3;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   dp_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   dp_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cs, input logic we,
                        input int aa, input int da, input int ab, input int db);
      bus.cs     = cs;
      bus.we     = we;
      bus.addr_a = AW'(aa);
      bus.data_a = DW'(da);
      bus.addr_b = AW'(ab);
      bus.data_b = DW'(db);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 0, 0, 0, 0);
      tick();
      check("por_aout", bus.data_aout, 3'd0);
      check("por_bout", bus.data_bout, 3'd0);
      #3 rst_n = 1'b1;

      // Store a word that the mid-sequence reset must discard
      drive(1'b1, 1'b1, 3, 5, 0, 0);
      tick();
      drive(1'b1, 1'b0, 3, 0, 0, 0);
      tick();
      check("pre_rst_rd_a3", bus.data_aout, 3'd5);
      drive(1'b0, 1'b1, 5, 0, 5, 6);
      tick();
      drive(1'b0, 1'b0, 0, 0, 5, 0);
      tick();
      check("pre_rst_rd_b5", bus.data_bout, 3'd6);

      // Mid-clock reset clears outputs without an edge
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_aout", bus.data_aout, 3'd0);
      check("rst_async_bout", bus.data_bout, 3'd0);
      tick();
      check("rst_hold_aout", bus.data_aout, 3'd0);
      #3 rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, i, 0, 0, 0);
         tick();
         check($sformatf("rst_rd_a%0d", i), bus.data_aout, 3'd0);
      end

      // Port A fill; writes must leave both outputs alone
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, i, i + 1, 7 - i, 7);
         tick();
         check($sformatf("fill_wr_aout%0d", i), bus.data_aout, 3'd0);
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, i, 0, 0, 0);
         tick();
         check($sformatf("fill_rd_a%0d", i), bus.data_aout, DW'(i + 1));
      end

      // Port B overwrite of the same addresses
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 6, 7, i, i);
         tick();
         check($sformatf("ovr_wr_bout%0d", i), bus.data_bout, 3'd0);
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 7, 0, i, 0);
         tick();
         check($sformatf("ovr_rd_b%0d", i), bus.data_bout, DW'(i));
         check($sformatf("ovr_hold_a%0d", i), bus.data_aout, 3'd5);
      end

      // Cross-port read; 5..7 include the address cleared by reset
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, i, 0, 1, 0);
         tick();
         check($sformatf("xrd_a%0d", i), bus.data_aout, (i < 5) ? DW'(i) : 3'd0);
         check($sformatf("xrd_hold_b%0d", i), bus.data_bout, 3'd4);
      end

      // Inactive port B inputs must be ignored during an A write
      drive(1'b1, 1'b1, 6, 3, 2, 7);
      tick();
      check("ign_wr_aout", bus.data_aout, 3'd0);
      check("ign_wr_bout", bus.data_bout, 3'd4);
      drive(1'b1, 1'b0, 2, 0, 6, 0);
      tick();
      check("ign_rd_a2", bus.data_aout, 3'd2);
      drive(1'b0, 1'b0, 2, 0, 6, 0);
      tick();
      check("ign_rd_b6", bus.data_bout, 3'd3);

      // Read right after write, top address, opposite ports
      drive(1'b0, 1'b1, 0, 0, 7, 6);
      tick();
      drive(1'b1, 1'b0, 7, 0, 0, 0);
      tick();
      check("raw_a7", bus.data_aout, 3'd6);

      // Glitching cs/we between edges has no effect before the edge
      #2 drive(1'b1, 1'b1, 7, 1, 0, 0);
      #2 drive(1'b0, 1'b0, 0, 0, 1, 0);
      #1;
      check("glitch_aout", bus.data_aout, 3'd6);
      tick();
      check("glitch_bout", bus.data_bout, 3'd1);
      drive(1'b1, 1'b0, 7, 0, 0, 0);
      tick();
      check("glitch_mem7", bus.data_aout, 3'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule : tb_dp_ram
